req_onehot_arbiter: RTL and testbench

- Upstream stage for the 4-to-2 encoder. It takes four raw, asynchronous request lines (buttons or interrupt sources) and synchronises them.
- It detects rising edges, latches pending events, and arbitrates round-robin.
- Output is a strictly one-hot 4-bit word with a valid/ready handshake, so the downstream encoder only ever sees a legal one-hot input or all-zero.

---
 rtl/req_onehot_arbiter.sv | 127 ++++++++++++
 tb/tb_req_onehot_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_onehot_arbiter.sv
// Request front end for the 4-to-2 encoder. It synchronises four raw request lines,
// latches their rising edges and offers them one at a time, round-robin, as a one-hot word.
module req_onehot_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  output logic [3:0] out_onehot,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] pending,
  output logic       overrun,
  input  logic       clr_overrun,
  output logic       fsm_state
);

  // Handshake: a word transfers on any rising edge where out_valid and out_ready are both 1.
  // While out_valid=1 and out_ready=0, out_onehot is held unchanged.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] sync_r [SYNC_STAGES];
  logic [3:0] sync_q, prev_q, rise;
  logic [1:0] ptr, cur_idx, base, winner, idx;
  logic       found, load, handshake;
  logic [3:0] grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= 4'b0000;
      prev_q <= 4'b0000;
    end else begin
      sync_r[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
      prev_q <= sync_q;
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];
  assign rise   = sync_q & ~prev_q;

  always_comb begin
    case (out_onehot)
      4'b0010: cur_idx = 2'd1;
      4'b0100: cur_idx = 2'd2;
      4'b1000: cur_idx = 2'd3;
      default: cur_idx = 2'd0;
    endcase
  end

  // Round-robin search of pending, ascending from base and wrapping.
  always_comb begin
    winner = base;
    found  = 1'b0;
    idx    = base;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // On a handshake the next winner is searched from the slot after the one just taken.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    base    = ptr;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          load    = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (out_ready) begin
          base = cur_idx + 2'd1;
          if (|pending) load = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == OFFER);
    fsm_state = state_q;
    handshake = (state_q == OFFER) && out_ready;
    grant     = load ? (4'b0001 << winner) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_onehot <= 4'b0000;
      ptr        <= 2'd0;
    end else begin
      if (load)           out_onehot <= grant;
      else if (handshake) out_onehot <= 4'b0000;
      if (handshake)      ptr        <= cur_idx + 2'd1;
    end
  end

  // A rise on a bit granted this same cycle is a fresh event, not a lost one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 4'b0000;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | rise;
      if (|(rise & pending & ~grant)) overrun <= 1'b1;
      else if (clr_overrun)           overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Bench for req_onehot_arbiter: directed scenarios followed by random traffic,
// every cycle compared against an event-level reference model.
module tb_req_onehot_arbiter;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst, out_ready, clr_overrun;
  logic [3:0] req_in;
  logic [3:0] out_onehot, pending;
  logic       out_valid, overrun, fsm_state;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [3:0] m_hist[$];
  bit         m_prev[4];
  bit         m_pend[4];
  int         m_ptr;
  int         m_cur;
  bit         m_ovr;

  req_onehot_arbiter #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .out_onehot(out_onehot),
    .out_valid(out_valid), .out_ready(out_ready), .pending(pending),
    .overrun(overrun), .clr_overrun(clr_overrun), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic model_reset();
    m_hist = {};
    repeat (SYNC_STAGES) m_hist.push_back(4'b0000);
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_ptr = 0;
    m_cur = -1;
    m_ovr = 1'b0;
  endtask

  function automatic int rr_pick(input int start);
    for (int k = 0; k < 4; k++)
      if (m_pend[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_edge();
    logic [3:0] s;
    bit rise[4];
    int g;
    bit lost;
    if (rst) begin
      model_reset();
      return;
    end
    s = m_hist.pop_front();
    m_hist.push_back(req_in);
    for (int i = 0; i < 4; i++) begin
      rise[i]   = s[i] && !m_prev[i];
      m_prev[i] = s[i];
    end
    g = -1;
    if (m_cur < 0) g = rr_pick(m_ptr);
    else if (out_ready) begin
      m_ptr = (m_cur + 1) % 4;
      g = rr_pick(m_ptr);
    end
    lost = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        if (m_pend[i] && i != g) lost = 1'b1;
        m_pend[i] = 1'b1;
      end else if (i == g) m_pend[i] = 1'b0;
    end
    if (lost) m_ovr = 1'b1;
    else if (clr_overrun) m_ovr = 1'b0;
    if (g >= 0) m_cur = g;
    else if (m_cur >= 0 && out_ready) m_cur = -1;
  endtask

  task automatic check_model();
    logic [3:0] exp_hot, exp_pend;
    exp_hot = (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
    for (int i = 0; i < 4; i++) exp_pend[i] = m_pend[i];
    check("model_onehot", out_onehot, exp_hot);
    check("model_valid", {3'b000, out_valid}, {3'b000, m_cur >= 0});
    check("model_pending", pending, exp_pend);
    check("model_overrun", {3'b000, overrun}, {3'b000, m_ovr});
    check("model_state", {3'b000, fsm_state}, {3'b000, m_cur >= 0});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (out_valid !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check("wait_valid", {3'b000, out_valid}, 4'b0001);
  endtask

  initial begin
    rst = 1'b1; req_in = 4'b0000; out_ready = 1'b0; clr_overrun = 1'b0;
    model_reset();
    step();
    step();
    check("rst_valid", {3'b000, out_valid}, 4'b0000);
    check("rst_onehot", out_onehot, 4'b0000);
    check("rst_pending", pending, 4'b0000);
    check("rst_overrun", {3'b000, overrun}, 4'b0000);

    // Latency from first sampling edge, single event for a held level
    rst = 1'b0; req_in = 4'b0100;
    step();
    step();
    check("lat_pend_early", pending, 4'b0000);
    step();
    check("lat_pend", pending, 4'b0100);
    check("lat_valid_early", {3'b000, out_valid}, 4'b0000);
    step();
    check("lat_valid", {3'b000, out_valid}, 4'b0001);
    check("lat_onehot", out_onehot, 4'b0100);
    check("lat_pend_cleared", pending, 4'b0000);
    out_ready = 1'b1;
    step();
    check("lat_drop", {3'b000, out_valid}, 4'b0000);
    check("lat_drop_onehot", out_onehot, 4'b0000);
    repeat (6) step();
    check("held_single_valid", {3'b000, out_valid}, 4'b0000);
    check("held_single_pend", pending, 4'b0000);

    // Round robin from ptr=0, back-to-back
    req_in = 4'b0000; rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    req_in = 4'b1111;
    wait_valid(10);
    for (int i = 0; i < 4; i++) begin
      check("rr_grant", out_onehot, 4'(1 << i));
      step();
    end
    check("rr_done", {3'b000, out_valid}, 4'b0000);
    req_in = 4'b0000;
    repeat (4) step();
    req_in = 4'b1001;
    wait_valid(10);
    check("ptr_wrapped", out_onehot, 4'b0001);
    step();
    check("ptr_next", out_onehot, 4'b1000);
    step();
    check("ptr_idle", {3'b000, out_valid}, 4'b0000);

    // Backpressure
    out_ready = 1'b0; req_in = 4'b0010;
    wait_valid(10);
    check("bp_grant", out_onehot, 4'b0010);
    req_in = 4'b1010;
    repeat (3) step();
    req_in = 4'b0010;
    repeat (4) step();
    check("bp_hold", out_onehot, 4'b0010);
    check("bp_pending", pending, 4'b1000);
    out_ready = 1'b1;
    step();
    check("bp_next", out_onehot, 4'b1000);
    check("bp_no_gap", {3'b000, out_valid}, 4'b0001);
    step();
    check("bp_idle", {3'b000, out_valid}, 4'b0000);

    // Overrun
    out_ready = 1'b0; req_in = 4'b0001;
    wait_valid(10);
    check("ovr_grant", out_onehot, 4'b0001);
    req_in = 4'b0011;
    repeat (3) step();
    req_in = 4'b0001;
    repeat (3) step();
    check("ovr_not_yet", {3'b000, overrun}, 4'b0000);
    req_in = 4'b0011;
    repeat (4) step();
    check("ovr_set", {3'b000, overrun}, 4'b0001);
    check("ovr_pending", pending, 4'b0010);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("ovr_clear", {3'b000, overrun}, 4'b0000);
    req_in = 4'b0001;
    repeat (3) step();
    req_in = 4'b0011;
    step();
    step();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("ovr_set_wins", {3'b000, overrun}, 4'b0001);
    clr_overrun = 1'b1; req_in = 4'b0000; out_ready = 1'b1;
    repeat (8) step();
    clr_overrun = 1'b0;
    check("ovr_drained", {3'b000, out_valid}, 4'b0000);
    check("ovr_cleared", {3'b000, overrun}, 4'b0000);

    // Rise on the bit being loaded at the handshake
    out_ready = 1'b0; req_in = 4'b1000;
    wait_valid(10);
    check("same_first", out_onehot, 4'b1000);
    req_in = 4'b1001;
    repeat (3) step();
    req_in = 4'b1000;
    repeat (3) step();
    check("same_pending", pending, 4'b0001);
    req_in = 4'b1001;
    step();
    step();
    out_ready = 1'b1;
    step();
    check("same_load", out_onehot, 4'b0001);
    check("same_repend", pending, 4'b0001);
    check("same_no_ovr", {3'b000, overrun}, 4'b0000);
    step();
    check("same_second", out_onehot, 4'b0001);
    check("same_second_valid", {3'b000, out_valid}, 4'b0001);
    check("same_second_pend", pending, 4'b0000);
    step();
    check("same_idle", {3'b000, out_valid}, 4'b0000);

    // Reset during an offer
    out_ready = 1'b0; req_in = 4'b0000;
    repeat (3) step();
    req_in = 4'b0001;
    wait_valid(10);
    req_in = 4'b1011;
    repeat (5) step();
    check("mid_pending", pending, 4'b1010);
    check("mid_valid", {3'b000, out_valid}, 4'b0001);
    rst = 1'b1; req_in = 4'b0000;
    step();
    rst = 1'b0;
    check("mid_rst_valid", {3'b000, out_valid}, 4'b0000);
    check("mid_rst_onehot", out_onehot, 4'b0000);
    check("mid_rst_pending", pending, 4'b0000);
    repeat (8) step();
    check("mid_quiet", {3'b000, out_valid}, 4'b0000);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) req_in[b] = ~req_in[b];
      out_ready   = ($urandom_range(0, 3) != 0);
      clr_overrun = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
